pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Holds the architectural PC and fetches one instruction at a time from instruction memory over a req/gnt/rvalid handshake.
- Presents {pc, instr} to decode with a valid/ready handshake.
- On each decode acceptance, loads the next PC produced by the NPC stage (npc_in), which is combinationally fed from this block's pc output.
- Sits between NPC and decode. Supports an asynchronous redirect (flush) with squash of a single in-flight response.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ALIGN_CHECK, 1, when 1 a misaligned PC raises if_excp instead of issuing a memory request.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- pc  output  32  current PC; drives the NPC stage PC input.
- npc_in  input  32  next PC from the NPC stage; sampled on the decode handshake.
- flush  input  1  redirect request; higher priority than npc_in.
- flush_pc  input  32  redirect target.
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  request address; always equals pc.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid; arrives at least 1 cycle after gnt.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  fetched instruction valid to decode.
- if_pc  output  32  PC of the presented instruction.
- if_instr  output  32  presented instruction.
- if_excp  output  1  presented slot is a misaligned-fetch exception.
- id_ready  input  1  decode accepts the slot.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=REQ, drop=0.
  - if_valid=0, if_excp=0, if_instr=0, if_pc=0; imem_req is 0 while rst=0.
  - Outputs return to normal on the first clk edge after rst rises.
- States:
  - REQ:
    - If ALIGN_CHECK=1 and pc[1:0]!=0: imem_req=0; next state HOLD with if_excp=1, if_instr=32'h0, if_pc=pc.
    - Otherwise imem_req=1. On imem_gnt go to WAIT; else stay in REQ.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid with drop=0: capture if_instr=imem_rdata, if_pc=pc, if_excp=0; go to HOLD.
    - On imem_rvalid with drop=1: discard data, clear drop, go to REQ.
  - HOLD:
    - if_valid=1. if_* held stable until accepted.
    - On id_ready: pc<=npc_in, go to REQ. if_valid drops in the next cycle.
- Throughput and latency:
  - Minimum 3 cycles per instruction with gnt in the same cycle as req and rvalid 1 cycle after gnt: REQ, WAIT, HOLD.
  - Handshake to new request: 1 cycle.
- Flush (has priority over every other event in the same cycle):
  - REQ without gnt: pc<=flush_pc, stay in REQ. The address changes only while the request is ungranted.
  - REQ with gnt in the same cycle: pc<=flush_pc, go to WAIT with drop=1.
  - WAIT without rvalid: pc<=flush_pc, drop<=1, stay in WAIT.
  - WAIT with rvalid in the same cycle: data discarded, pc<=flush_pc, drop<=0, go to REQ.
  - HOLD, with or without id_ready: slot squashed, if_valid<=0, pc<=flush_pc, go to REQ. npc_in is ignored.
  - Repeated flushes while drop=1: the latest flush_pc wins; still exactly one response is discarded.
- Ordering and fault handling:
  - At most one outstanding request.
  - imem_rvalid in REQ or HOLD is a protocol error and is ignored.
- Width and wrap rules:
  - PC arithmetic is done in NPC; this block does no addition.
  - npc_in and flush_pc are taken verbatim.
  - Wrap from 32'hFFFF_FFFC to 0 is the NPC stage's concern; this block accepts any value.
- Reset mid-operation: any in-flight response arriving after reset release is ignored, because the block re-enters REQ with drop=0 and imem_rvalid in REQ is ignored. The memory must also be reset.

Test Plan:
- Reset then release; memory with gnt=1 and rvalid 1 cycle later; npc_in=pc+4, id_ready=1.
  -> imem_addr sequence 3000, 3004, 3008; if_valid pulses every 3rd cycle with matching if_pc/if_instr.
- id_ready=0 for 5 cycles in HOLD.
  -> if_valid, if_pc and if_instr stable for 5 cycles; no imem_req; pc unchanged; advance on the 6th cycle.
- Flush flush_pc=32'h0000_4000 in WAIT, rvalid 2 cycles later carrying 32'hDEADBEEF.
  -> DEADBEEF never presented; next imem_addr=4000; if_pc=4000.
- flush asserted in the same cycle as imem_gnt.
  -> enter WAIT with drop=1; first rvalid discarded; a second request is issued at flush_pc.
- npc_in=32'h0000_3002 accepted with ALIGN_CHECK=1.
  -> no imem_req; if_valid=1, if_excp=1, if_pc=3002, if_instr=0.
- Assert rst low during WAIT, then release.
  -> outputs zero immediately (async); pc=3000; the fresh request is at 3000; a stale rvalid is ignored.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, fetches one word at a time
// over req/gnt/rvalid and presents {pc, instr} to decode; flush redirects the PC.
`timescale 1ns/1ps

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] npc_in,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_excp,
    input  logic        id_ready,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        armed_q;
    logic [31:0] ipc_q, iinstr_q;
    logic        iexcp_q;
    logic        cap_data, cap_excp;
    logic        misaligned;

    assign misaligned = ALIGN_CHECK && (pc_q[1:0] != 2'b00);

    // Handshakes: a request is granted on a clk edge with imem_req && imem_gnt;
    // a decode slot transfers on a clk edge with if_valid && id_ready.
    // armed_q keeps imem_req low until the first edge after reset release.
    assign imem_req  = armed_q && (state_q == S_REQ) && !misaligned;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign if_valid  = (state_q == S_HOLD);
    assign if_pc     = ipc_q;
    assign if_instr  = iinstr_q;
    assign if_excp   = iexcp_q && (state_q == S_HOLD);
    assign dbg_state = state_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        drop_d   = drop_q;
        cap_data = 1'b0;
        cap_excp = 1'b0;
        case (state_q)
            S_REQ: begin
                if (flush) begin
                    pc_d = flush_pc;
                    if (imem_req && imem_gnt) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (armed_q && misaligned) begin
                    state_d  = S_HOLD;
                    cap_excp = 1'b1;
                end else if (imem_req && imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    pc_d = flush_pc;
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        cap_data = 1'b1;
                        state_d  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // A flush squashes the presented slot even if decode takes it this cycle.
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = S_REQ;
                end else if (id_ready) begin
                    pc_d    = npc_in;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            armed_q  <= 1'b0;
            ipc_q    <= 32'h0;
            iinstr_q <= 32'h0;
            iexcp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            armed_q <= 1'b1;
            if (cap_data) begin
                ipc_q    <= pc_q;
                iinstr_q <= imem_rdata;
                iexcp_q  <= 1'b0;
            end else if (cap_excp) begin
                ipc_q    <= pc_q;
                iinstr_q <= 32'h0;
                iexcp_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed fetch/stall/flush/misalign/reset scenarios,
// then randomized memory, decode and redirect traffic against a PC-level model.
`timescale 1ns/1ps

module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, npc_in, flush_pc, imem_addr, imem_rdata, if_pc, if_instr;
    logic        flush, imem_req, imem_gnt, imem_rvalid, if_valid, if_excp, id_ready;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RESET_PC), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .pc(pc), .npc_in(npc_in), .flush(flush), .flush_pc(flush_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_pc(if_pc), .if_instr(if_instr), .if_excp(if_excp), .id_ready(id_ready),
        .dbg_state(dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // outstanding request addresses as seen on the memory bus
    logic [31:0] exp_q[$];

    int gnt_pct = 100, dly_min = 1, dly_max = 1, rdy_pct = 100;
    int flush_pct = 0, npc_rand_pct = 0, mis_pct = 0, junk_pct = 0;
    logic        force_flush = 1'b0, force_npc = 1'b0, force_stale = 1'b0;
    logic [31:0] force_fpc = 32'h0, force_npc_v = 32'h0;
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_data = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if (roll(mis_pct)) a[1:0] = 2'($urandom_range(1, 3));
        else a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive decode, redirect and memory inputs for the current cycle.
    task automatic drive();
        id_ready = roll(rdy_pct);
        if (force_npc) npc_in = force_npc_v;
        else if (roll(npc_rand_pct)) npc_in = rand_addr();
        else npc_in = pc + 32'd4;
        flush    = force_flush || roll(flush_pct);
        flush_pc = force_flush ? force_fpc : rand_addr();
        force_flush = 1'b0;
        force_npc   = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_data;
                mem_pend    = 1'b0;
            end
        end else if (force_stale || roll(junk_pct)) begin
            imem_rvalid = 1'b1;
        end
        force_stale = 1'b0;
        imem_gnt = roll(gnt_pct);
        if (imem_req && imem_gnt) begin
            mem_pend = 1'b1;
            mem_cnt  = int'($urandom_range(dly_min, dly_max));
            mem_data = mem_word(imem_addr);
        end
    endtask

    task automatic tick();
        drive();
        @(negedge clk);
    endtask

    task automatic wait_req(input int lim);
        int n = 0;
        while (!imem_req && n < lim) begin tick(); n++; end
        if (!imem_req) begin
            total++; bad++;
            $display("FAIL wait_req: imem_req=0 after %0d cycles, want 1", lim);
        end
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (!if_valid && n < lim) begin tick(); n++; end
        if (!if_valid) begin
            total++; bad++;
            $display("FAIL wait_valid: if_valid=0 after %0d cycles, want 1", lim);
        end
    endtask

    // Per-cycle compare against the PC-level model.
    initial begin : cmp
        logic [31:0] m_pc;
        logic        p_valid, p_ready, p_flush;
        int          idle;
        m_pc = RESET_PC; p_valid = 1'b0; p_ready = 1'b0; p_flush = 1'b0; idle = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("rst_if_valid", 32'(if_valid), 32'h0);
                chk("rst_if_excp", 32'(if_excp), 32'h0);
                chk("rst_imem_req", 32'(imem_req), 32'h0);
                chk("rst_if_pc", if_pc, 32'h0);
                chk("rst_if_instr", if_instr, 32'h0);
                chk("rst_pc", pc, RESET_PC);
                m_pc = RESET_PC; p_valid = 1'b0; idle = 0;
                exp_q.delete();
            end else begin
                chk("pc", pc, m_pc);
                chk("imem_addr", imem_addr, m_pc);
                if (imem_req) chk("req_aligned", 32'(m_pc[1:0]), 32'h0);
                if (if_valid) begin
                    chk("if_pc", if_pc, m_pc);
                    chk("req_in_hold", 32'(imem_req), 32'h0);
                    if (m_pc[1:0] != 2'b00) begin
                        chk("if_excp", 32'(if_excp), 32'h1);
                        chk("if_instr_excp", if_instr, 32'h0);
                    end else begin
                        chk("if_excp", 32'(if_excp), 32'h0);
                        chk("if_instr", if_instr, mem_word(m_pc));
                    end
                end
                if (p_valid) begin
                    if (!p_ready && !p_flush) begin
                        chk("hold_valid", 32'(if_valid), 32'h1);
                    end else begin
                        chk("drop_valid", 32'(if_valid), 32'h0);
                        chk("next_req", 32'(imem_req), 32'(m_pc[1:0] == 2'b00));
                    end
                end
                if (imem_rvalid && exp_q.size() > 0) void'(exp_q.pop_front());
                if (imem_req && imem_gnt) begin
                    chk("outstanding", 32'(exp_q.size()), 32'h0);
                    exp_q.push_back(imem_addr);
                end
                if (if_valid || flush) idle = 0;
                else idle++;
                if (idle > 60) begin
                    total++; bad++;
                    $display("FAIL progress: %0d cycles without a slot, want <= 60", idle);
                    idle = 0;
                end
                p_valid = if_valid; p_ready = id_ready; p_flush = flush;
                if (flush) m_pc = flush_pc;
                else if (if_valid && id_ready) m_pc = npc_in;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] e;
        rst = 1'b0; npc_in = 32'h0; flush = 1'b0; flush_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
        @(negedge clk);
        chk("t0_pc", pc, 32'h0000_3000);
        chk("t0_valid", 32'(if_valid), 32'h0);
        chk("t0_req", 32'(imem_req), 32'h0);
        tick();
        rst = 1'b1;

        // back-to-back fetch: REQ, WAIT, HOLD per instruction
        wait_req(5);
        for (int i = 0; i < 9; i++) begin
            e = 32'h0000_3000 + 32'(4 * (i / 3));
            chk("t1_req", 32'(imem_req), 32'(i % 3 == 0));
            if (i % 3 == 0) chk("t1_addr", imem_addr, e);
            chk("t1_valid", 32'(if_valid), 32'(i % 3 == 2));
            if (i % 3 == 2) begin
                chk("t1_if_pc", if_pc, e);
                chk("t1_if_instr", if_instr, mem_word(e));
            end
            tick();
        end

        // decode stall for 5 cycles
        rdy_pct = 0;
        wait_valid(10);
        for (int k = 0; k < 5; k++) begin
            chk("t2_valid", 32'(if_valid), 32'h1);
            chk("t2_if_pc", if_pc, 32'h0000_300C);
            chk("t2_if_instr", if_instr, mem_word(32'h0000_300C));
            chk("t2_req", 32'(imem_req), 32'h0);
            chk("t2_pc", pc, 32'h0000_300C);
            tick();
        end
        rdy_pct = 100;
        chk("t2_valid6", 32'(if_valid), 32'h1);
        tick();
        chk("t2_after_valid", 32'(if_valid), 32'h0);
        chk("t2_after_req", 32'(imem_req), 32'h1);
        chk("t2_after_addr", imem_addr, 32'h0000_3010);

        // flush in WAIT; the stale response carries DEADBEEF
        dly_min = 3; dly_max = 3;
        tick();
        mem_data = 32'hDEAD_BEEF;
        chk("t3_wait_req", 32'(imem_req), 32'h0);
        force_flush = 1'b1; force_fpc = 32'h0000_4000;
        tick();
        wait_req(10);
        chk("t3_addr", imem_addr, 32'h0000_4000);
        wait_valid(15);
        chk("t3_if_pc", if_pc, 32'h0000_4000);
        chk("t3_if_instr", if_instr, mem_word(32'h0000_4000));
        chk("t3_if_excp", 32'(if_excp), 32'h0);
        dly_min = 1; dly_max = 1;
        tick();

        // flush in the same cycle as the grant
        wait_req(10);
        chk("t4_addr0", imem_addr, 32'h0000_4004);
        force_flush = 1'b1; force_fpc = 32'h0000_5000;
        tick();
        mem_data = 32'hBAD0_0001;
        chk("t4_wait_req", 32'(imem_req), 32'h0);
        chk("t4_wait_addr", imem_addr, 32'h0000_5000);
        tick();
        chk("t4_req", 32'(imem_req), 32'h1);
        chk("t4_addr", imem_addr, 32'h0000_5000);
        chk("t4_valid", 32'(if_valid), 32'h0);
        wait_valid(10);
        chk("t4_if_pc", if_pc, 32'h0000_5000);
        chk("t4_if_instr", if_instr, mem_word(32'h0000_5000));

        // misaligned next PC raises an exception slot
        force_npc = 1'b1; force_npc_v = 32'h0000_3002;
        tick();
        chk("t5_req", 32'(imem_req), 32'h0);
        chk("t5_pc", pc, 32'h0000_3002);
        tick();
        chk("t5_valid", 32'(if_valid), 32'h1);
        chk("t5_excp", 32'(if_excp), 32'h1);
        chk("t5_if_pc", if_pc, 32'h0000_3002);
        chk("t5_if_instr", if_instr, 32'h0);
        chk("t5_req_hold", 32'(imem_req), 32'h0);
        force_npc = 1'b1; force_npc_v = 32'h0000_3100;
        tick();

        // reset during WAIT, then a stale response after release
        wait_req(10);
        dly_min = 3; dly_max = 3;
        tick();
        chk("t6_wait_req", 32'(imem_req), 32'h0);
        rst = 1'b0;
        #1;
        chk("t6_valid", 32'(if_valid), 32'h0);
        chk("t6_pc", pc, 32'h0000_3000);
        chk("t6_req", 32'(imem_req), 32'h0);
        chk("t6_if_instr", if_instr, 32'h0);
        mem_pend = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b1;
        gnt_pct = 0;
        tick();
        chk("t6_req_rel", 32'(imem_req), 32'h1);
        chk("t6_addr_rel", imem_addr, 32'h0000_3000);
        force_stale = 1'b1;
        tick();
        chk("t6_req_stale", 32'(imem_req), 32'h1);
        chk("t6_valid_stale", 32'(if_valid), 32'h0);
        gnt_pct = 100; dly_min = 1; dly_max = 1;
        wait_valid(10);
        chk("t6_if_pc", if_pc, 32'h0000_3000);
        chk("t6_if_instr", if_instr, mem_word(32'h0000_3000));
        tick();

        // randomized traffic
        gnt_pct = 60; dly_min = 1; dly_max = 4; rdy_pct = 70;
        flush_pct = 6; npc_rand_pct = 10; mis_pct = 10; junk_pct = 4;
        repeat (3000) tick();
        flush_pct = 0; junk_pct = 0;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
